// File: rtl/seg_decode_monitor.sv
// Receive-side monitor for a seven-segment digit bus: glitch filter, BCD decode,
// modulo-10 sequence check, digit period measurement and saturating error count.
module seg_decode_monitor #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned PERIOD_W      = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          segments,
    output logic [3:0]          digit,
    output logic                digit_valid,
    output logic                bad_pattern,
    output logic                seq_err,
    output logic                locked,
    output logic [PERIOD_W-1:0] period,
    output logic [7:0]          err_count
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t              state, state_nx;
    logic [6:0]          seg_q;
    logic [6:0]          accepted, accepted_nx;
    logic [SW-1:0]       stab_cnt, stab_nx;
    logic [PERIOD_W-1:0] cyc_cnt, cyc_nx;
    logic [PERIOD_W-1:0] period_nx;
    logic [3:0]          digit_nx;
    logic                dv_nx, bp_nx, se_nx;
    logic [7:0]          err_nx;
    logic [7:0]          err_inc;
    logic                accept;
    logic                is_digit;
    logic                is_blank;
    logic [3:0]          dec;
    logic [3:0]          digit_succ;

    always_comb begin
        is_digit = 1'b1;
        dec      = 4'd0;
        case (seg_q)
            7'h3F:   dec = 4'd0;
            7'h06:   dec = 4'd1;
            7'h5B:   dec = 4'd2;
            7'h4F:   dec = 4'd3;
            7'h66:   dec = 4'd4;
            7'h6D:   dec = 4'd5;
            7'h7D:   dec = 4'd6;
            7'h07:   dec = 4'd7;
            7'h7F:   dec = 4'd8;
            7'h6F:   dec = 4'd9;
            default: is_digit = 1'b0;
        endcase
        is_blank = (seg_q == '0);
    end

    always_comb begin
        if (segments != seg_q) begin
            stab_nx = '0;
        end else if (stab_cnt == STAB_MAX) begin
            stab_nx = stab_cnt;
        end else begin
            stab_nx = stab_cnt + 1'b1;
        end
    end

    // stab_cnt counts matching pairs; STABLE_CYCLES-1 pairs means STABLE_CYCLES equal samples
    assign accept     = (stab_cnt >= STAB_LAST) && (seg_q != accepted);
    assign digit_succ = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    assign err_inc    = (&err_count) ? err_count : err_count + 8'd1;

    always_comb begin
        state_nx    = state;
        accepted_nx = accepted;
        digit_nx    = digit;
        dv_nx       = 1'b0;
        bp_nx       = 1'b0;
        se_nx       = 1'b0;
        period_nx   = period;
        err_nx      = err_count;
        cyc_nx      = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;

        if (accept) begin
            accepted_nx = seg_q;
            if (is_blank) begin
                state_nx = IDLE;
            end else if (!is_digit) begin
                bp_nx    = 1'b1;
                err_nx   = err_inc;
                state_nx = IDLE;
            end else begin
                dv_nx    = 1'b1;
                digit_nx = dec;
                cyc_nx   = PERIOD_W'(1);
                state_nx = LOCKED;
                if (state == LOCKED) begin
                    period_nx = cyc_cnt;
                    if (dec != digit_succ) begin
                        se_nx  = 1'b1;
                        err_nx = err_inc;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            seg_q       <= '0;
            accepted    <= '0;
            stab_cnt    <= '0;
            cyc_cnt     <= '0;
            digit       <= '0;
            digit_valid <= 1'b0;
            bad_pattern <= 1'b0;
            seq_err     <= 1'b0;
            period      <= '0;
            err_count   <= '0;
        end else begin
            state       <= state_nx;
            seg_q       <= segments;
            accepted    <= accepted_nx;
            stab_cnt    <= stab_nx;
            cyc_cnt     <= cyc_nx;
            digit       <= digit_nx;
            digit_valid <= dv_nx;
            bad_pattern <= bp_nx;
            seq_err     <= se_nx;
            period      <= period_nx;
            err_count   <= err_nx;
        end
    end

    assign locked = (state == LOCKED);

endmodule
